// File: rtl/dmac_axi_pkg.sv
// rtl/dmac_axi_pkg.sv - shared AXI constants and index-width helper for the DMAC master mux
package dmac_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmac_rr_arb.sv
// rtl/dmac_rr_arb.sv - round-robin arbiter; pointer moves past the winner on accept
module dmac_rr_arb
    import dmac_axi_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_accept,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N))
                w_cand = w_cand - (IW+1)'(N);
            if (!o_valid && i_req[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
        o_grant = o_valid ? (N'(1) << o_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (i_accept)
            r_ptr <= (o_idx == IW'(N-1)) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/dmac_axi_mux.sv
// rtl/dmac_axi_mux.sv - N-channel AXI master mux: RR AR/AW, AW-ordered W, ID-routed R/B
module dmac_axi_mux
    import dmac_axi_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*ADDR_W-1:0]     ch_araddr_i,
    input  logic [N_CH*4-1:0]          ch_arlen_i,
    input  logic [N_CH*3-1:0]          ch_arsize_i,
    input  logic [N_CH*2-1:0]          ch_arburst_i,
    input  logic [N_CH-1:0]            ch_arvalid_i,
    output logic [N_CH-1:0]            ch_arready_o,
    input  logic [N_CH*ADDR_W-1:0]     ch_awaddr_i,
    input  logic [N_CH*4-1:0]          ch_awlen_i,
    input  logic [N_CH*3-1:0]          ch_awsize_i,
    input  logic [N_CH*2-1:0]          ch_awburst_i,
    input  logic [N_CH-1:0]            ch_awvalid_i,
    output logic [N_CH-1:0]            ch_awready_o,
    input  logic [N_CH*DATA_W-1:0]     ch_wdata_i,
    input  logic [N_CH*DATA_W/8-1:0]   ch_wstrb_i,
    input  logic [N_CH-1:0]            ch_wlast_i,
    input  logic [N_CH-1:0]            ch_wvalid_i,
    output logic [N_CH-1:0]            ch_wready_o,
    output logic [N_CH-1:0]            ch_rvalid_o,
    input  logic [N_CH-1:0]            ch_rready_i,
    output logic [N_CH-1:0]            ch_bvalid_o,
    input  logic [N_CH-1:0]            ch_bready_i,
    output logic [ID_W-1:0]            arid_o,
    output logic [ADDR_W-1:0]          araddr_o,
    output logic [3:0]                 arlen_o,
    output logic [2:0]                 arsize_o,
    output logic [1:0]                 arburst_o,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    output logic [ID_W-1:0]            awid_o,
    output logic [ADDR_W-1:0]          awaddr_o,
    output logic [3:0]                 awlen_o,
    output logic [2:0]                 awsize_o,
    output logic [1:0]                 awburst_o,
    output logic                       awvalid_o,
    input  logic                       awready_i,
    output logic [ID_W-1:0]            wid_o,
    output logic [DATA_W-1:0]          wdata_o,
    output logic [DATA_W/8-1:0]        wstrb_o,
    output logic                       wlast_o,
    output logic                       wvalid_o,
    input  logic                       wready_i,
    input  logic [ID_W-1:0]            rid_i,
    input  logic                       rvalid_i,
    output logic                       rready_o,
    input  logic [ID_W-1:0]            bid_i,
    input  logic                       bvalid_i,
    output logic                       bready_o,
    output logic                       bad_id_o
);

    localparam int IDX_W  = idx_w(N_CH);
    localparam int STRB_W = DATA_W/8;
    localparam int QA_W   = $clog2(WQ_DEPTH);

    logic [N_CH-1:0]   w_ar_grant, w_aw_grant;
    logic [IDX_W-1:0]  w_ar_idx, w_aw_idx;
    logic              w_ar_valid, w_aw_valid;
    logic              w_ar_load, w_aw_load;
    logic [ADDR_W-1:0] w_ar_addr, w_aw_addr;
    logic [3:0]        w_ar_len, w_aw_len;
    logic [2:0]        w_ar_size, w_aw_size;
    logic [1:0]        w_ar_burst, w_aw_burst;

    logic [IDX_W-1:0]  r_fifo [WQ_DEPTH];
    logic [QA_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [QA_W:0]     r_cnt;
    logic              w_empty, w_full, w_pop;
    logic [IDX_W-1:0]  w_head;
    logic              w_rid_ok, w_bid_ok;

    dmac_rr_arb #(.N(N_CH)) u_ar_arb (
        .clk(clk), .rst(rst), .i_req(ch_arvalid_i), .i_accept(w_ar_load),
        .o_grant(w_ar_grant), .o_idx(w_ar_idx), .o_valid(w_ar_valid)
    );

    dmac_rr_arb #(.N(N_CH)) u_aw_arb (
        .clk(clk), .rst(rst), .i_req(ch_awvalid_i), .i_accept(w_aw_load),
        .o_grant(w_aw_grant), .o_idx(w_aw_idx), .o_valid(w_aw_valid)
    );

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (QA_W+1)'(WQ_DEPTH));
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_pop   = !w_empty && wvalid_o && wready_i && wlast_o;

    assign w_ar_load = (!arvalid_o || arready_i) && w_ar_valid;
    // A same-cycle W-last pop frees the slot this AW push needs.
    assign w_aw_load = (!awvalid_o || awready_i) && w_aw_valid && (!w_full || w_pop);
    assign ch_arready_o = w_ar_load ? w_ar_grant : '0;
    assign ch_awready_o = w_aw_load ? w_aw_grant : '0;

    always_comb begin
        w_ar_addr = '0; w_ar_len = '0; w_ar_size = '0; w_ar_burst = '0;
        w_aw_addr = '0; w_aw_len = '0; w_aw_size = '0; w_aw_burst = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_ar_idx == IDX_W'(c)) begin
                w_ar_addr  = ch_araddr_i[c*ADDR_W +: ADDR_W];
                w_ar_len   = ch_arlen_i[c*4 +: 4];
                w_ar_size  = ch_arsize_i[c*3 +: 3];
                w_ar_burst = ch_arburst_i[c*2 +: 2];
            end
            if (w_aw_idx == IDX_W'(c)) begin
                w_aw_addr  = ch_awaddr_i[c*ADDR_W +: ADDR_W];
                w_aw_len   = ch_awlen_i[c*4 +: 4];
                w_aw_size  = ch_awsize_i[c*3 +: 3];
                w_aw_burst = ch_awburst_i[c*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_o <= 1'b0; arid_o <= '0; araddr_o <= '0;
            arlen_o <= '0; arsize_o <= '0; arburst_o <= '0;
        end else if (w_ar_load) begin
            arvalid_o <= 1'b1; arid_o <= ID_W'(w_ar_idx); araddr_o <= w_ar_addr;
            arlen_o <= w_ar_len; arsize_o <= w_ar_size; arburst_o <= w_ar_burst;
        end else if (arready_i) begin
            arvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_o <= 1'b0; awid_o <= '0; awaddr_o <= '0;
            awlen_o <= '0; awsize_o <= '0; awburst_o <= '0;
        end else if (w_aw_load) begin
            awvalid_o <= 1'b1; awid_o <= ID_W'(w_aw_idx); awaddr_o <= w_aw_addr;
            awlen_o <= w_aw_len; awsize_o <= w_aw_size; awburst_o <= w_aw_burst;
        end else if (awready_i) begin
            awvalid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_load)
            r_fifo[r_wr_ptr] <= w_aw_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_aw_load) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_aw_load && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_aw_load && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // W follows the AW grant order: only the FIFO head channel may talk.
    always_comb begin
        wvalid_o    = 1'b0;
        wid_o       = '0;
        wdata_o     = '0;
        wstrb_o     = '0;
        wlast_o     = 1'b0;
        ch_wready_o = '0;
        if (!w_empty) begin
            wid_o = ID_W'(w_head);
            for (int c = 0; c < N_CH; c++) begin
                if (w_head == IDX_W'(c)) begin
                    wvalid_o       = ch_wvalid_i[c];
                    wdata_o        = ch_wdata_i[c*DATA_W +: DATA_W];
                    wstrb_o        = ch_wstrb_i[c*STRB_W +: STRB_W];
                    wlast_o        = ch_wlast_i[c];
                    ch_wready_o[c] = wready_i;
                end
            end
        end
    end

    assign w_rid_ok = ({1'b0, rid_i} < (ID_W+1)'(N_CH));
    assign w_bid_ok = ({1'b0, bid_i} < (ID_W+1)'(N_CH));

    always_comb begin
        ch_rvalid_o = '0;
        ch_bvalid_o = '0;
        rready_o    = !w_rid_ok;
        bready_o    = !w_bid_ok;
        for (int c = 0; c < N_CH; c++) begin
            if (rid_i == ID_W'(c)) begin
                ch_rvalid_o[c] = rvalid_i;
                rready_o       = ch_rready_i[c];
            end
            if (bid_i == ID_W'(c)) begin
                ch_bvalid_o[c] = bvalid_i;
                bready_o       = ch_bready_i[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bad_id_o <= 1'b0;
        else
            bad_id_o <= (rvalid_i && !w_rid_ok) || (bvalid_i && !w_bid_ok);
    end

endmodule

// File: doc/dmac_axi_mux.md
Name: dmac_axi_mux

Overview:
- Parametrised N-channel AXI master multiplexer for the multi-channel DMAC.
- Merges the per-channel AR/AW/W streams of N_CH DMAC engines onto one AXI master port.
- Demultiplexes R/B responses back to the channels by ID.
- Successor to the fixed 4-channel top-level muxing: channel count is a parameter, AR/AW use registered round-robin arbitration, and W bursts are ordered by an AW-grant-order FIFO instead of free W arbitration.

Parameters:
- N_CH, 4, number of DMA channels (2..16; must satisfy N_CH <= 2**ID_W).
- ID_W, 4, AXI ID width. Channel c uses ID = c.
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.
- WQ_DEPTH, 4, depth of the AW-order FIFO (power of 2). Also the maximum number of granted AW bursts whose W data is not yet finished.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ch_araddr_i  in  N_CH*ADDR_W  per-channel AR address; channel c occupies slice [c*ADDR_W +: ADDR_W]
- ch_arlen_i  in  N_CH*4  AR length
- ch_arsize_i  in  N_CH*3  AR size
- ch_arburst_i  in  N_CH*2  AR burst type
- ch_arvalid_i  in  N_CH  AR valid
- ch_arready_o  out  N_CH  AR ready
- ch_awaddr_i, ch_awlen_i, ch_awsize_i, ch_awburst_i, ch_awvalid_i, ch_awready_o: same widths, directions and slicing as the AR group
- ch_wdata_i  in  N_CH*DATA_W  write data
- ch_wstrb_i  in  N_CH*DATA_W/8  write strobes
- ch_wlast_i  in  N_CH  W last
- ch_wvalid_i  in  N_CH  W valid
- ch_wready_o  out  N_CH  W ready
- ch_rvalid_o  out  N_CH  R valid; R data fields are broadcast to all channels
- ch_rready_i  in  N_CH  R ready
- ch_bvalid_o  out  N_CH  B valid
- ch_bready_i  in  N_CH  B ready
- arid_o/araddr_o/arlen_o/arsize_o/arburst_o/arvalid_o  out; arready_i  in: AXI AR master port
- awid_o/awaddr_o/awlen_o/awsize_o/awburst_o/awvalid_o  out; awready_i  in: AXI AW master port
- wid_o  out  ID_W;  wdata_o  out  DATA_W;  wstrb_o  out  DATA_W/8;  wlast_o/wvalid_o  out  1;  wready_i  in  1
- rid_i  in  ID_W;  rvalid_i  in  1;  rready_o  out  1
- bid_i  in  ID_W;  bvalid_i  in  1;  bready_o  out  1
- bad_id_o  out  1  one-cycle pulse when an R or B beat with an out-of-range ID is accepted

Behaviour:
- Reset (rst=1, asynchronous):
  - arvalid_o, awvalid_o, all AR/AW output fields and bad_id_o = 0.
  - AR and AW round-robin pointers = 0.
  - W-order FIFO emptied.
  - Reset mid-burst discards any partial W burst; no recovery attempted.
- AR arbitration:
  - Output register is "free" when arvalid_o=0 or (arvalid_o & arready_i).
  - When free, pick the first c with ch_arvalid_i[c]=1, scanning from the pointer upward with wrap at N_CH.
  - Load {ID=c, fields of c} into the output register and assert ch_arready_o[c] for that same cycle only (combinational off the free + winner logic).
  - Pointer <= c+1 mod N_CH.
  - Latency: 1 cycle from ch_arvalid_i to arvalid_o. A back-to-back accept sustains 1 AR per cycle.
  - arvalid_o stays high with stable fields until arready_i.
- AW arbitration: identical to AR, with one extra load condition: FIFO not full, or a W-last pop happens in the same cycle.
  - On each load, push the winner index c into the W-order FIFO.
- W path (combinational, no register):
  - head = FIFO front.
  - If FIFO empty: wvalid_o=0 and all ch_wready_o=0.
  - Otherwise: wvalid_o = ch_wvalid_i[head]; wdata/wstrb/wlast from channel head; wid_o = head; ch_wready_o[head] = wready_i; other ch_wready_o = 0.
  - Pop when wvalid_o & wready_i & wlast_o.
  - W data may not lead its AW grant. The W beats of a burst are forwarded only once that burst's channel index is at the FIFO head, i.e. after its AW has been granted.
- Simultaneous FIFO events:
  - Push and pop in the same cycle leave the count unchanged.
  - Push while full is allowed only if a pop occurs in that cycle.
- R demux:
  - For c = rid_i < N_CH: ch_rvalid_o[c] = rvalid_i and rready_o = ch_rready_i[c]; all other ch_rvalid_o = 0.
  - For rid_i >= N_CH: rready_o = 1, the beat is dropped, and bad_id_o pulses (registered, 1 cycle after the handshake).
- B demux: same rules as R, using bid_i, bvalid_i and ch_bready_i.

Decomposition:
- Package dmac_axi_pkg holds burst-type constants (FIXED/INCR/WRAP), response codes, and the function clog2-based index width IDX_W = $clog2(N_CH).
- Sub-module dmac_rr_arb (N parameter): request vector in, grant one-hot + index out, pointer update on "accept". Instantiated twice, for AR and AW.
- The W-order FIFO is written inline (pointers + count).

Test Plan:
- Reset mid-AW: assert rst while awvalid_o=1 and FIFO holds 2 entries -> awvalid_o=0 immediately; FIFO empty; no W forwarded afterwards until a new AW grant.
- All 4 channels assert arvalid with arready_i=1 constantly -> arid_o sequence 0,1,2,3,0 on consecutive cycles, each ch_arready_o pulse exactly 1 cycle.
- ch2 AW len=3 granted before ch0 AW len=1; ch0 presents W first -> ch0 wready held 0 until 4 ch2 beats complete with wlast; then ch0's 2 beats forwarded with wid_o=0.
- WQ_DEPTH=4, wready_i=0, 5 AW requests -> exactly 4 AW accepted and the 5th stalls. Then one wlast pop with a simultaneous 5th AW load -> count remains 4.
- R beats with rid_i=1 then rid_i=7 (N_CH=4) -> first routed to ch1 only, with rready_o following ch_rready_i[1]; second accepted with rready_o=1 and bad_id_o pulses 1 cycle.
- arready_i held 0 for 5 cycles -> araddr_o/arid_o stable and no additional ch_arready_o pulses during the stall.
